// File: rtl/stackCPU_DEFS.sv
// Shared stack CPU definitions: CPU opcodes, CPU core states, and the
// program loader state type.
package stackCPU_DEFS;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_PUSH = 4'h1,
    OP_POP  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_JMP  = 4'h5,
    OP_JZ   = 4'h6,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    CPU_FETCH,
    CPU_DECODE,
    CPU_EXECUTE,
    CPU_HALTED
  } cpu_state_t;

  typedef enum logic [1:0] {
    LDR_IDLE,
    LDR_LOAD,
    LDR_RUN,
    LDR_ERROR
  } loader_state_t;

endpackage

// File: rtl/stack_program_loader_if.sv
// Host load channel plus CPU fetch/status signals of the program loader.
//   master : host/CPU side (drives start, load_*, pc)
//   slave  : loader side (drives load_ready, instruction, status)
interface stack_program_loader_if #(
  parameter int INSTR_WIDTH = 16,
  parameter int PC_WIDTH    = 10
);
  logic                   start;
  logic [INSTR_WIDTH-1:0] load_data;
  logic                   load_valid;
  logic                   load_last;
  logic                   load_ready;
  logic [PC_WIDTH-1:0]    pc;
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   cpu_reset;
  logic [PC_WIDTH:0]      prog_len;
  logic                   loaded;
  logic                   overflow;

  modport master (
    output start, load_data, load_valid, load_last, pc,
    input  load_ready, instruction, cpu_reset, prog_len, loaded, overflow
  );

  modport slave (
    input  start, load_data, load_valid, load_last, pc,
    output load_ready, instruction, cpu_reset, prog_len, loaded, overflow
  );
endinterface

// File: rtl/program_ram.sv
// Program storage: single clock, one write port, one registered read port.
// Contents are intentionally not reset.
//   clk     : clock
//   wr_en   : write wr_data to mem[wr_addr]
//   rd_addr : read address, rd_data valid one cycle later
module program_ram #(
  parameter int INSTR_WIDTH = 16,
  parameter int PC_WIDTH    = 10
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [PC_WIDTH-1:0]    wr_addr,
  input  logic [INSTR_WIDTH-1:0] wr_data,
  input  logic [PC_WIDTH-1:0]    rd_addr,
  output logic [INSTR_WIDTH-1:0] rd_data
);
  logic [INSTR_WIDTH-1:0] mem [2**PC_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/stack_program_loader.sv
// Loads a program from a host stream into program RAM, holds the CPU in
// reset while loading, then serves instruction fetches.
//   clk, reset : clock, async active-high reset
//   bus        : host load channel, CPU fetch port and status (slave side)
//
// state | meaning
// IDLE  | no program yet, CPU held in reset
// LOAD  | accepting words from the host
// RUN   | program resident, CPU running
// ERROR | load ran past the last address, CPU held in reset
module stack_program_loader
  import stackCPU_DEFS::*;
#(
  parameter int                     INSTR_WIDTH = 16,
  parameter int                     PC_WIDTH    = 10,
  parameter logic [INSTR_WIDTH-1:0] FILL_WORD   = '1
) (
  input  logic                   clk,
  input  logic                   reset,
  stack_program_loader_if.slave  bus
);
  localparam logic [PC_WIDTH-1:0] TOP_ADDR = '1;
  localparam logic [PC_WIDTH-1:0] PTR_ONE  = PC_WIDTH'(1);
  localparam logic [PC_WIDTH:0]   CNT_ONE  = (PC_WIDTH + 1)'(1);

  loader_state_t          state_q, state_d;
  logic [PC_WIDTH-1:0]    wr_ptr_q;
  logic [PC_WIDTH:0]      count_q;
  logic [PC_WIDTH:0]      prog_len_q;
  logic                   cpu_reset_q;
  logic                   rd_ok_q;
  logic                   xfer;
  logic [INSTR_WIDTH-1:0] ram_q;

  // start in LOAD restarts the load, so a word offered that cycle is dropped
  assign xfer = (state_q == LDR_LOAD) && bus.load_valid && !bus.start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= LDR_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = LDR_LOAD;
    end else if (xfer) begin
      if (bus.load_last)            state_d = LDR_RUN;
      else if (wr_ptr_q == TOP_ADDR) state_d = LDR_ERROR;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      prog_len_q  <= '0;
      cpu_reset_q <= 1'b1;
      rd_ok_q     <= 1'b0;
    end else begin
      if (bus.start) begin
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else if (xfer) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
        count_q  <= count_q + CNT_ONE;
      end
      if (xfer && bus.load_last) prog_len_q <= count_q + CNT_ONE;
      cpu_reset_q <= (state_d != LDR_RUN);
      // qualifies the RAM read so stale words beyond prog_len never leak out
      rd_ok_q <= (state_q == LDR_RUN) && ({1'b0, bus.pc} < prog_len_q);
    end
  end

  program_ram #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .PC_WIDTH    (PC_WIDTH)
  ) u_program_ram (
    .clk     (clk),
    .wr_en   (xfer),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.load_data),
    .rd_addr (bus.pc),
    .rd_data (ram_q)
  );

  assign bus.load_ready  = (state_q == LDR_LOAD);
  assign bus.instruction = rd_ok_q ? ram_q : FILL_WORD;
  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.prog_len    = prog_len_q;
  assign bus.loaded      = (state_q == LDR_RUN);
  assign bus.overflow    = (state_q == LDR_ERROR);
endmodule

// File: tb/tb_stack_program_loader.sv
module tb_stack_program_loader;
  localparam int IW  = 16;
  localparam int PW  = 10;
  localparam int PWS = 2;
  localparam logic [IW-1:0] FILL = '1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_program_loader_if #(.INSTR_WIDTH(IW), .PC_WIDTH(PW))  a_if ();
  stack_program_loader_if #(.INSTR_WIDTH(IW), .PC_WIDTH(PWS)) b_if ();

  stack_program_loader #(.INSTR_WIDTH(IW), .PC_WIDTH(PW), .FILL_WORD(FILL)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if.slave));
  stack_program_loader #(.INSTR_WIDTH(IW), .PC_WIDTH(PWS), .FILL_WORD(FILL)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // reference model for dut_a: memory image, resident length, running flag
  logic [IW-1:0] ref_mem [2**PW];
  int            ref_len;
  bit            ref_run;
  logic [IW-1:0] b_mem [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_a();
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
    ref_run = 1'b0;
  endtask

  // random idle cycles (with a stray load_last) before each offered word
  task automatic send_a(input logic [IW-1:0] d, input bit last, input int addr);
    int gap;
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      a_if.load_valid = 1'b0;
      a_if.load_last  = 1'($urandom_range(0, 1));
      a_if.load_data  = IW'($urandom);
      tick();
    end
    a_if.load_valid = 1'b1;
    a_if.load_last  = last;
    a_if.load_data  = d;
    tick();
    a_if.load_valid = 1'b0;
    a_if.load_last  = 1'b0;
    ref_mem[addr] = d;
    if (last) begin
      ref_len = addr + 1;
      ref_run = 1'b1;
    end
  endtask

  task automatic load_random(input int n);
    start_a();
    for (int i = 0; i < n; i++) send_a(IW'($urandom), (i == n - 1), i);
  endtask

  task automatic read_a(input string tag, input int addr);
    logic [IW-1:0] exp;
    a_if.pc = PW'(addr);
    tick();
    exp = (ref_run && addr < ref_len) ? ref_mem[addr] : FILL;
    check(tag, 32'(a_if.instruction), 32'(exp));
  endtask

  task automatic status_a(input string tag);
    check({tag, "_loaded"},   32'(a_if.loaded),    32'(ref_run));
    check({tag, "_cpu_rst"},  32'(a_if.cpu_reset), 32'(!ref_run));
    check({tag, "_prog_len"}, 32'(a_if.prog_len),  32'(ref_len));
    check({tag, "_overflow"}, 32'(a_if.overflow),  32'(0));
  endtask

  initial begin
    int n;
    reset = 1'b1;
    a_if.start = 0; a_if.load_data = '0; a_if.load_valid = 0; a_if.load_last = 0; a_if.pc = '0;
    b_if.start = 0; b_if.load_data = '0; b_if.load_valid = 0; b_if.load_last = 0; b_if.pc = '0;
    ref_len = 0;
    ref_run = 1'b0;
    tick(); tick();
    check("rst_ready", 32'(a_if.load_ready), 32'(0));
    check("rst_instr", 32'(a_if.instruction), 32'(FILL));
    status_a("rst");
    reset = 1'b0;
    tick();

    // three-word program
    start_a();
    check("l3_ready", 32'(a_if.load_ready), 32'(1));
    send_a(16'h0101, 1'b0, 0);
    send_a(16'h0202, 1'b0, 1);
    check("l3_mid_cpu_rst", 32'(a_if.cpu_reset), 32'(1));
    send_a(16'h0303, 1'b1, 2);
    check("l3_len", 32'(a_if.prog_len), 32'(3));
    check("l3_cpu_rst_fell", 32'(a_if.cpu_reset), 32'(0));
    check("l3_ready_off", 32'(a_if.load_ready), 32'(0));
    read_a("l3_pc0", 0);
    check("l3_pc0_val", 32'(a_if.instruction), 32'h0101);
    read_a("l3_pc1", 1);
    read_a("l3_pc2", 2);
    read_a("l3_pc3", 3);

    // host stalls mid-load
    start_a();
    send_a(16'h1111, 1'b0, 0);
    a_if.load_valid = 1'b0;
    a_if.load_last  = 1'b1;
    a_if.load_data  = 16'hDEAD;
    tick(); tick();
    a_if.load_last = 1'b0;
    check("stall_len_held", 32'(a_if.prog_len), 32'(3));
    check("stall_loaded", 32'(a_if.loaded), 32'(0));
    send_a(16'h2222, 1'b0, 1);
    send_a(16'h3333, 1'b1, 2);
    status_a("stall");
    read_a("stall_pc0", 0);
    read_a("stall_pc1", 1);
    read_a("stall_pc2", 2);

    // random programs
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 12);
      load_random(n);
      status_a("rnd");
      for (int k = 0; k < 5; k++) read_a("rnd_rd", $urandom_range(0, n + 2));
    end

    // restart from RUN with a one-word program; old words stay hidden
    load_random(4);
    status_a("pre_restart");
    start_a();
    check("restart_loaded", 32'(a_if.loaded), 32'(0));
    check("restart_len_kept", 32'(a_if.prog_len), 32'(4));
    send_a(16'hAAAA, 1'b1, 0);
    status_a("one_word");
    read_a("one_pc0", 0);
    check("one_pc0_val", 32'(a_if.instruction), 32'hAAAA);
    read_a("one_pc1", 1);
    check("one_pc1_fill", 32'(a_if.instruction), 32'(FILL));

    // start coinciding with a valid word drops that word
    start_a();
    send_a(16'h5A5A, 1'b0, 0);
    a_if.start = 1'b1; a_if.load_valid = 1'b1; a_if.load_last = 1'b1; a_if.load_data = 16'hBAD0;
    tick();
    a_if.start = 1'b0; a_if.load_valid = 1'b0; a_if.load_last = 1'b0;
    check("drop_loaded", 32'(a_if.loaded), 32'(0));
    check("drop_len", 32'(a_if.prog_len), 32'(ref_len));
    send_a(16'h1234, 1'b0, 0);
    send_a(16'h5678, 1'b1, 1);
    status_a("drop");
    read_a("drop_pc0", 0);
    check("drop_pc0_val", 32'(a_if.instruction), 32'h1234);
    read_a("drop_pc1", 1);

    // async reset mid-load, then reload
    start_a();
    send_a(IW'($urandom), 1'b0, 0);
    send_a(IW'($urandom), 1'b0, 1);
    #2 reset = 1'b1;
    #1;
    ref_len = 0;
    ref_run = 1'b0;
    check("arst_ready", 32'(a_if.load_ready), 32'(0));
    check("arst_instr", 32'(a_if.instruction), 32'(FILL));
    status_a("arst");
    reset = 1'b0;
    tick();
    load_random(2);
    status_a("reload");
    read_a("reload_pc0", 0);
    read_a("reload_pc1", 1);
    read_a("reload_pc2", 2);

    // small memory: overflow, then a load that exactly fills it
    b_if.start = 1'b1; tick(); b_if.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_if.load_valid = 1'b1; b_if.load_last = 1'b0; b_if.load_data = IW'($urandom);
      tick();
    end
    b_if.load_valid = 1'b0;
    check("ovf_flag", 32'(b_if.overflow), 32'(1));
    check("ovf_cpu_rst", 32'(b_if.cpu_reset), 32'(1));
    check("ovf_loaded", 32'(b_if.loaded), 32'(0));
    check("ovf_ready", 32'(b_if.load_ready), 32'(0));
    b_if.pc = '0;
    tick();
    check("ovf_instr", 32'(b_if.instruction), 32'(FILL));
    b_if.start = 1'b1; tick(); b_if.start = 1'b0;
    check("ovf_restart", 32'(b_if.overflow), 32'(0));
    for (int i = 0; i < 4; i++) begin
      b_mem[i] = IW'($urandom);
      b_if.load_valid = 1'b1; b_if.load_last = (i == 3); b_if.load_data = b_mem[i];
      tick();
    end
    b_if.load_valid = 1'b0; b_if.load_last = 1'b0;
    check("full_len", 32'(b_if.prog_len), 32'(4));
    check("full_loaded", 32'(b_if.loaded), 32'(1));
    check("full_overflow", 32'(b_if.overflow), 32'(0));
    for (int i = 0; i < 4; i++) begin
      b_if.pc = PWS'(i);
      tick();
      check("full_rd", 32'(b_if.instruction), 32'(b_mem[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stack_program_loader.md
STACK_PROGRAM_LOADER -- requirements
Module: stack_program_loader

Interface
REQ-001 INSTR_WIDTH, 16, instruction word width in bits, shall be a parameter.
REQ-002 PC_WIDTH, 10, program address width in bits, shall be a parameter; memory depth is 2**PC_WIDTH.
REQ-003 FILL_WORD, all ones, word returned for unloaded or out-of-program addresses, shall be a parameter.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 start  input  1  request a new program load (single-cycle pulse).
REQ-007 load_data  input  INSTR_WIDTH  instruction word offered by the host.
REQ-008 load_valid  input  1  load_data/load_last are valid.
REQ-009 load_last  input  1  the current word is the final program word.
REQ-010 load_ready  output  1  loader accepts a word this cycle.
REQ-011 pc  input  PC_WIDTH  instruction address from the CPU.
REQ-012 instruction  output  INSTR_WIDTH  registered instruction word for the CPU.
REQ-013 cpu_reset  output  1  holds the CPU in reset while high.
REQ-014 prog_len  output  PC_WIDTH+1  number of words in the loaded program.
REQ-015 loaded  output  1  a complete program is resident and the CPU is running.
REQ-016 overflow  output  1  the load exceeded memory depth.

Function
REQ-017 The FSM shall have states IDLE, LOAD, RUN and ERROR.
REQ-018 IDLE: start goes to LOAD; otherwise stay.
REQ-019 RUN: start goes to LOAD; otherwise stay.
REQ-020 ERROR: stay until start (goes to LOAD) or reset.
REQ-021 On entry to LOAD, the write pointer and word count shall clear to 0.
REQ-022 load_ready shall be 1 only in LOAD.
REQ-023 A transfer occurs on any cycle with load_valid=1 and load_ready=1; it writes load_data to mem[write pointer] and increments the pointer and count by 1.
REQ-024 A transfer with load_last=1 shall load prog_len with the post-increment count and move to RUN on the same edge.
REQ-025 A transfer at pointer 2**PC_WIDTH-1 with load_last=0 shall move to ERROR, with that word written; it shall not wrap.
REQ-026 load_last without load_valid shall have no effect.
REQ-027 start asserted in LOAD shall restart the load: pointer and count clear, and any transfer on that cycle is ignored.
REQ-028 cpu_reset shall be 1 in IDLE, LOAD and ERROR, and 0 only in RUN; it is registered, so it falls one cycle after the last transfer.
REQ-029 loaded shall equal (state==RUN); overflow shall equal (state==ERROR).
REQ-030 instruction is a synchronous read with 1-cycle latency: it shall take mem[pc] when state==RUN and pc<prog_len, else FILL_WORD.
REQ-031 Memory contents shall persist across loads; words at or beyond prog_len shall never be visible on instruction.
REQ-032 prog_len shall hold its value until the next completed load; it is not cleared on entry to LOAD.

Reset
REQ-033 Asynchronous reset shall force: state IDLE, pointer 0, count 0, prog_len 0, instruction FILL_WORD, cpu_reset 1, load_ready 0, loaded 0, overflow 0.
REQ-034 Memory contents shall not be reset.
REQ-035 Reset mid-LOAD shall abandon the load, and the next load shall start at address 0.

Structure
REQ-036 The loader state enum shall live in the shared stackCPU_DEFS package alongside the CPU opcode and state types.
REQ-037 Storage shall be one sub-module, program_ram: single clock, one write port, one registered read port, parameterized by INSTR_WIDTH and PC_WIDTH.

Verification
REQ-038 Load 3 words 0x0101, 0x0202, 0x0303 (last on the third) -> prog_len=3; cpu_reset falls the next cycle; pc=0,1,2 yields those words one cycle later; pc=3 yields FILL_WORD.
REQ-039 Host drops load_valid for 2 cycles mid-load -> no write while invalid; count and contents are unaffected.
REQ-040 PC_WIDTH=2, load 4 words with no last -> ERROR after the 4th; overflow=1, cpu_reset=1, instruction=FILL_WORD.
REQ-041 start during RUN, then load 1 word 0xAAAA -> prog_len=1; pc=0 returns 0xAAAA; pc=1 returns FILL_WORD even though old data remains in memory.
REQ-042 reset asserted after 2 of 5 transfers -> all outputs at reset values immediately; a reload of 2 words gives prog_len=2.
REQ-043 start and a valid transfer in the same LOAD cycle -> the word is discarded; the next transfer writes address 0.
